// File: rtl/address_unit.sv
// Program counter and memory address register for the CPU datapath.
// Jump targets are staged a byte at a time so an untaken jump leaves the PC untouched.
module address_unit #(
    parameter logic [15:0] ORIGIN = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  bus_in,
    input  logic        load_origin,
    input  logic        pc_enable,
    input  logic        load_pc_low_byte,
    input  logic        load_pc_high_byte,
    input  logic        load_mar_pc,
    input  logic        load_mar_addr_low,
    input  logic        load_mar_addr_high,
    output logic [15:0] pc_out,
    output logic [15:0] mar_out,
    output logic        jump_pending,
    output logic        pc_wrapped
);

    logic [15:0] pc;
    logic [15:0] mar;
    logic [7:0]  shadow_lo;
    logic        pending;
    logic        wrapped;

    logic [15:0] pc_next;
    logic [15:0] mar_next;
    logic [7:0]  shadow_next;
    logic        pending_next;
    logic        wrapped_next;
    logic [7:0]  jump_low;

    // Low byte of a committed jump: a same-cycle low load beats the staged byte,
    // and with nothing staged the current PC low byte is kept.
    always_comb begin
        jump_low = pc[7:0];
        if (load_pc_low_byte) begin
            jump_low = bus_in;
        end else if (pending) begin
            jump_low = shadow_lo;
        end
    end

    always_comb begin
        pc_next      = pc;
        shadow_next  = shadow_lo;
        pending_next = pending;
        wrapped_next = wrapped;
        if (load_origin) begin
            pc_next      = ORIGIN;
            pending_next = 1'b0;
        end else if (load_pc_high_byte) begin
            pc_next      = {bus_in, jump_low};
            pending_next = 1'b0;
        end else if (load_pc_low_byte) begin
            shadow_next  = bus_in;
            pending_next = 1'b1;
        end else begin
            // No jump load this cycle: any staged byte is abandoned.
            pending_next = 1'b0;
            if (pc_enable) begin
                pc_next = pc + 16'd1;
                if (pc == 16'hFFFF) begin
                    wrapped_next = 1'b1;
                end
            end
        end
    end

    always_comb begin
        mar_next = mar;
        if (load_mar_pc) begin
            mar_next = pc;
        end else begin
            if (load_mar_addr_low) begin
                mar_next[7:0] = bus_in;
            end
            if (load_mar_addr_high) begin
                mar_next[15:8] = bus_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= '0;
            mar       <= '0;
            shadow_lo <= '0;
            pending   <= 1'b0;
            wrapped   <= 1'b0;
        end else begin
            pc        <= pc_next;
            mar       <= mar_next;
            shadow_lo <= shadow_next;
            pending   <= pending_next;
            wrapped   <= wrapped_next;
        end
    end

    assign pc_out       = pc;
    assign mar_out      = mar;
    assign jump_pending = pending;
    assign pc_wrapped   = wrapped;

endmodule

// File: tb/tb_address_unit.sv
// Self-checking bench for address_unit: vector table with expected-result queue,
// plus hand sequences for origin priority and asynchronous reset mid-jump.
module tb_address_unit;

    localparam logic [6:0] C_O  = 7'b1000000;
    localparam logic [6:0] C_E  = 7'b0100000;
    localparam logic [6:0] C_L  = 7'b0010000;
    localparam logic [6:0] C_H  = 7'b0001000;
    localparam logic [6:0] C_MP = 7'b0000100;
    localparam logic [6:0] C_ML = 7'b0000010;
    localparam logic [6:0] C_MH = 7'b0000001;

    typedef struct {
        logic [6:0]  ctrl;
        logic [7:0]  bus;
        logic [15:0] pc;
        logic [15:0] mar;
        logic        pend;
        logic        wrap;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] mar;
        logic        pend;
        logic        wrap;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  bus_in = '0;
    logic        load_origin = 1'b0;
    logic        pc_enable = 1'b0;
    logic        load_pc_low_byte = 1'b0;
    logic        load_pc_high_byte = 1'b0;
    logic        load_mar_pc = 1'b0;
    logic        load_mar_addr_low = 1'b0;
    logic        load_mar_addr_high = 1'b0;

    logic [15:0] pc_out, mar_out, pc_out_b, mar_out_b;
    logic        jump_pending, pc_wrapped, jump_pending_b, pc_wrapped_b;

    int n_total = 0;
    int n_pass  = 0;

    vec_t vecs[$];
    exp_t sb[$];

    address_unit #(.ORIGIN(16'hF000)) dut (
        .clk(clk), .reset(reset), .bus_in(bus_in),
        .load_origin(load_origin), .pc_enable(pc_enable),
        .load_pc_low_byte(load_pc_low_byte), .load_pc_high_byte(load_pc_high_byte),
        .load_mar_pc(load_mar_pc), .load_mar_addr_low(load_mar_addr_low),
        .load_mar_addr_high(load_mar_addr_high),
        .pc_out(pc_out), .mar_out(mar_out),
        .jump_pending(jump_pending), .pc_wrapped(pc_wrapped)
    );

    address_unit #(.ORIGIN(16'h0100)) dut_b (
        .clk(clk), .reset(reset), .bus_in(bus_in),
        .load_origin(load_origin), .pc_enable(pc_enable),
        .load_pc_low_byte(load_pc_low_byte), .load_pc_high_byte(load_pc_high_byte),
        .load_mar_pc(load_mar_pc), .load_mar_addr_low(load_mar_addr_low),
        .load_mar_addr_high(load_mar_addr_high),
        .pc_out(pc_out_b), .mar_out(mar_out_b),
        .jump_pending(jump_pending_b), .pc_wrapped(pc_wrapped_b)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [6:0] ctrl, input logic [7:0] bus,
                                input logic [15:0] pc, input logic [15:0] mar,
                                input logic pend, input logic wrap);
        vec_t v;
        v.ctrl = ctrl; v.bus = bus; v.pc = pc; v.mar = mar; v.pend = pend; v.wrap = wrap;
        return v;
    endfunction

    task automatic drive(input logic [6:0] ctrl, input logic [7:0] bus);
        load_origin        = ctrl[6];
        pc_enable          = ctrl[5];
        load_pc_low_byte   = ctrl[4];
        load_pc_high_byte  = ctrl[3];
        load_mar_pc        = ctrl[2];
        load_mar_addr_low  = ctrl[1];
        load_mar_addr_high = ctrl[0];
        bus_in             = bus;
    endtask

    task automatic step(input string tag, input vec_t v);
        exp_t e;
        @(negedge clk);
        drive(v.ctrl, v.bus);
        e.pc = v.pc; e.mar = v.mar; e.pend = v.pend; e.wrap = v.wrap;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, " pc"},   pc_out, e.pc);
        check({tag, " mar"},  mar_out, e.mar);
        check({tag, " pend"}, {15'b0, jump_pending}, {15'b0, e.pend});
        check({tag, " wrap"}, {15'b0, pc_wrapped}, {15'b0, e.wrap});
    endtask

    initial begin
        // ctrl, bus, expected pc, mar, pending, wrapped
        vecs.push_back(mk(C_O,        8'h00, 16'hF000, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(C_L,        8'h10, 16'hF000, 16'h0000, 1'b1, 1'b0));
        vecs.push_back(mk(C_H,        8'h00, 16'h0010, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(C_L,        8'h34, 16'h0010, 16'h0000, 1'b1, 1'b0));
        vecs.push_back(mk(C_H,        8'h12, 16'h1234, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(C_L,        8'h10, 16'h1234, 16'h0000, 1'b1, 1'b0));
        vecs.push_back(mk(C_H,        8'h00, 16'h0010, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(C_L,        8'h34, 16'h0010, 16'h0000, 1'b1, 1'b0));
        vecs.push_back(mk(7'b0,       8'h00, 16'h0010, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(C_H,        8'hAB, 16'hAB10, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(C_L,        8'h55, 16'hAB10, 16'h0000, 1'b1, 1'b0));
        vecs.push_back(mk(C_E,        8'h00, 16'hAB11, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(C_L,        8'h11, 16'hAB11, 16'h0000, 1'b1, 1'b0));
        vecs.push_back(mk(C_L,        8'h22, 16'hAB11, 16'h0000, 1'b1, 1'b0));
        vecs.push_back(mk(C_H,        8'h33, 16'h3322, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(C_L|C_H,    8'h77, 16'h7777, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(C_L,        8'h01, 16'h7777, 16'h0000, 1'b1, 1'b0));
        vecs.push_back(mk(C_L|C_H,    8'h99, 16'h9999, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(C_L|C_E,    8'h44, 16'h9999, 16'h0000, 1'b1, 1'b0));
        vecs.push_back(mk(C_H|C_E,    8'h88, 16'h8844, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(C_L,        8'hFE, 16'h8844, 16'h0000, 1'b1, 1'b0));
        vecs.push_back(mk(C_H,        8'hFF, 16'hFFFE, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(C_E,        8'h00, 16'hFFFF, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(C_E,        8'h00, 16'h0000, 16'h0000, 1'b0, 1'b1));
        vecs.push_back(mk(C_O,        8'h00, 16'hF000, 16'h0000, 1'b0, 1'b1));
        vecs.push_back(mk(C_L,        8'h00, 16'hF000, 16'h0000, 1'b1, 1'b1));
        vecs.push_back(mk(C_H,        8'h02, 16'h0200, 16'h0000, 1'b0, 1'b1));
        vecs.push_back(mk(C_MP|C_E,   8'h00, 16'h0201, 16'h0200, 1'b0, 1'b1));
        vecs.push_back(mk(C_ML,       8'h78, 16'h0201, 16'h0278, 1'b0, 1'b1));
        vecs.push_back(mk(C_MH,       8'h56, 16'h0201, 16'h5678, 1'b0, 1'b1));
        vecs.push_back(mk(C_ML|C_MH,  8'hAA, 16'h0201, 16'hAAAA, 1'b0, 1'b1));
        vecs.push_back(mk(C_MP|C_ML|C_MH|C_E, 8'h11, 16'h0202, 16'h0201, 1'b0, 1'b1));
        vecs.push_back(mk(C_E,        8'h00, 16'h0203, 16'h0201, 1'b0, 1'b1));
        vecs.push_back(mk(C_E,        8'h00, 16'h0204, 16'h0201, 1'b0, 1'b1));
        vecs.push_back(mk(C_L,        8'h66, 16'h0204, 16'h0201, 1'b1, 1'b1));

        // Reset state while reset is held
        repeat (2) @(posedge clk);
        #1;
        check("reset pc",   pc_out, 16'h0000);
        check("reset mar",  mar_out, 16'h0000);
        check("reset pend", {15'b0, jump_pending}, 16'h0000);
        check("reset wrap", {15'b0, pc_wrapped}, 16'h0000);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Origin beats high-byte load and increment, and cancels the staged byte
        step("prio", mk(C_O|C_H|C_E, 8'h12, 16'hF000, 16'h0201, 1'b0, 1'b1));
        check("prio_b pc",   pc_out_b, 16'h0100);
        check("prio_b pend", {15'b0, jump_pending_b}, 16'h0000);

        // Asynchronous reset in the middle of a jump
        step("midjump", mk(C_L, 8'h5A, 16'hF000, 16'h0201, 1'b1, 1'b1));
        @(negedge clk);
        drive(7'b0, 8'h00);
        #2;
        reset = 1'b0;
        #1;
        check("async pc",   pc_out, 16'h0000);
        check("async mar",  mar_out, 16'h0000);
        check("async pend", {15'b0, jump_pending}, 16'h0000);
        check("async wrap", {15'b0, pc_wrapped}, 16'h0000);
        check("async_b pc", pc_out_b, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        step("post_reset", mk(7'b0, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0));
        // Staged low byte was cleared by reset: high-only load uses pc[7:0]
        step("post_reset_hi", mk(C_H, 8'hC3, 16'hC300, 16'h0000, 1'b0, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
